// File: rtl/fano_sync_ctrl.sv
// ============================================================================
//  Module   : fano_sync_ctrl
//  Brief    : Acquisition scheduler for fano_decoder. Sweeps phase/diff/rate
//             hypotheses, confirms sync, supervises lock and re-acquires.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fano_sync_ctrl #(
    parameter int TIMEOUT_WIDTH = 24,
    parameter int NUM_RATES     = 4,
    parameter int RST_CYCLES    = 4,
    parameter int LOSS_LIMIT    = 16
) (
    input  logic                     CLK,
    input  logic                     nRESET,
    input  logic                     i_enable,
    input  logic                     i_vld,
    input  logic                     i_is_sync,
    input  logic [TIMEOUT_WIDTH-1:0] i_timeout,
    input  logic [7:0]               i_confirm,
    output logic                     o_dec_reset_n,
    output logic [1:0]               o_phase,
    output logic                     o_diff_en,
    output logic [1:0]               o_code_rate,
    output logic [4:0]               o_hyp_idx,
    output logic                     o_locked,
    output logic                     o_lost,
    output logic                     o_sweep_wrap
);

    localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int LW = (LOSS_LIMIT > 1) ? $clog2(LOSS_LIMIT + 1) : 1;

    localparam logic [RW-1:0]            c_rst_last = RW'(RST_CYCLES - 1);
    localparam logic [RW-1:0]            c_rst_one  = RW'(1);
    localparam logic [LW:0]              c_loss_lim = (LW + 1)'(LOSS_LIMIT);
    localparam logic [LW:0]              c_loss_one = (LW + 1)'(1);
    localparam logic [TIMEOUT_WIDTH-1:0] c_tmo_one  = TIMEOUT_WIDTH'(1);
    localparam logic [4:0]               c_hyp_last = 5'(8 * NUM_RATES - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RST_DEC   = 3'd1,
        S_WAIT_SYNC = 3'd2,
        S_CONFIRM   = 3'd3,
        S_LOCKED    = 3'd4
    } state_t;

    state_t                   r_state;
    logic [RW-1:0]            r_rst_cnt;
    logic [TIMEOUT_WIDTH-1:0] r_sym_cnt;
    logic [7:0]               r_conf_cnt;
    logic [LW-1:0]            r_loss_cnt;
    logic [4:0]               r_hyp;
    logic                     r_dec_reset_n;
    logic                     r_locked;
    logic                     r_lost;
    logic                     r_wrap;

    logic                     w_tmo_hit;
    logic [7:0]               w_conf_target;
    logic [8:0]               w_conf_next;
    logic [LW:0]              w_loss_next;
    logic                     w_hyp_wrap;
    logic [4:0]               w_hyp_next;

    // ">=" rather than "==" so a live-lowered timeout still fires on the next symbol
    assign w_tmo_hit     = i_vld && (i_timeout != '0) && (r_sym_cnt >= (i_timeout - c_tmo_one));
    assign w_conf_target = (i_confirm == 8'd0) ? 8'd1 : i_confirm;
    assign w_conf_next   = {1'b0, r_conf_cnt} + 9'd1;
    assign w_loss_next   = {1'b0, r_loss_cnt} + c_loss_one;
    assign w_hyp_wrap    = (r_hyp == c_hyp_last);
    assign w_hyp_next    = w_hyp_wrap ? 5'd0 : (r_hyp + 5'd1);

    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            r_state       <= S_IDLE;
            r_rst_cnt     <= '0;
            r_sym_cnt     <= '0;
            r_conf_cnt    <= '0;
            r_loss_cnt    <= '0;
            r_hyp         <= '0;
            r_dec_reset_n <= 1'b0;
            r_locked      <= 1'b0;
            r_lost        <= 1'b0;
            r_wrap        <= 1'b0;
        end else begin
            r_lost <= 1'b0;
            r_wrap <= 1'b0;
            if (!i_enable) begin
                r_state       <= S_IDLE;
                r_rst_cnt     <= '0;
                r_sym_cnt     <= '0;
                r_conf_cnt    <= '0;
                r_loss_cnt    <= '0;
                r_hyp         <= '0;
                r_dec_reset_n <= 1'b0;
                r_locked      <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_dec_reset_n <= 1'b0;
                        r_hyp         <= '0;
                        r_rst_cnt     <= '0;
                        r_state       <= S_RST_DEC;
                    end
                    S_RST_DEC: begin
                        if (r_rst_cnt == c_rst_last) begin
                            r_dec_reset_n <= 1'b1;
                            r_sym_cnt     <= '0;
                            r_state       <= S_WAIT_SYNC;
                        end else begin
                            r_rst_cnt <= r_rst_cnt + c_rst_one;
                        end
                    end
                    S_WAIT_SYNC: begin
                        if (i_vld && (r_sym_cnt != '1)) begin
                            r_sym_cnt <= r_sym_cnt + c_tmo_one;
                        end
                        if (i_is_sync) begin
                            r_conf_cnt <= '0;
                            r_state    <= S_CONFIRM;
                        end else if (w_tmo_hit) begin
                            r_hyp         <= w_hyp_next;
                            r_wrap        <= w_hyp_wrap;
                            r_dec_reset_n <= 1'b0;
                            r_rst_cnt     <= '0;
                            r_state       <= S_RST_DEC;
                        end
                    end
                    S_CONFIRM: begin
                        if (!i_is_sync) begin
                            r_hyp         <= w_hyp_next;
                            r_wrap        <= w_hyp_wrap;
                            r_dec_reset_n <= 1'b0;
                            r_rst_cnt     <= '0;
                            r_state       <= S_RST_DEC;
                        end else if (i_vld) begin
                            if (w_conf_next >= {1'b0, w_conf_target}) begin
                                r_locked   <= 1'b1;
                                r_loss_cnt <= '0;
                                r_state    <= S_LOCKED;
                            end else begin
                                r_conf_cnt <= w_conf_next[7:0];
                            end
                        end
                    end
                    S_LOCKED: begin
                        if (i_vld) begin
                            if (i_is_sync) begin
                                r_loss_cnt <= '0;
                            end else if (w_loss_next >= c_loss_lim) begin
                                // Retry the hypothesis that was locked before sweeping on
                                r_locked      <= 1'b0;
                                r_lost        <= 1'b1;
                                r_loss_cnt    <= '0;
                                r_dec_reset_n <= 1'b0;
                                r_rst_cnt     <= '0;
                                r_state       <= S_RST_DEC;
                            end else begin
                                r_loss_cnt <= w_loss_next[LW-1:0];
                            end
                        end
                    end
                    default: begin
                        r_state       <= S_IDLE;
                        r_dec_reset_n <= 1'b0;
                        r_locked      <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_dec_reset_n = r_dec_reset_n;
    assign o_phase       = r_hyp[1:0];
    assign o_diff_en     = r_hyp[2];
    assign o_code_rate   = r_hyp[4:3];
    assign o_hyp_idx     = r_hyp;
    assign o_locked      = r_locked;
    assign o_lost        = r_lost;
    assign o_sweep_wrap  = r_wrap;

endmodule

`default_nettype wire

// File: tb/tb_fano_sync_ctrl.sv
// ============================================================================
//  Module   : tb_fano_sync_ctrl
//  Brief    : Self-checking bench for fano_sync_ctrl against a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fano_sync_ctrl;

    localparam int TW = 24;
    localparam int NR = 4;
    localparam int RC = 4;
    localparam int LL = 16;
    localparam int NHYP = 8 * NR;

    logic          CLK = 1'b0;
    logic          nRESET;
    logic          i_enable;
    logic          i_vld;
    logic          i_is_sync;
    logic [TW-1:0] i_timeout;
    logic [7:0]    i_confirm;
    wire           o_dec_reset_n;
    wire  [1:0]    o_phase;
    wire           o_diff_en;
    wire  [1:0]    o_code_rate;
    wire  [4:0]    o_hyp_idx;
    wire           o_locked;
    wire           o_lost;
    wire           o_sweep_wrap;

    fano_sync_ctrl #(
        .TIMEOUT_WIDTH (TW),
        .NUM_RATES     (NR),
        .RST_CYCLES    (RC),
        .LOSS_LIMIT    (LL)
    ) u_dut (
        .CLK           (CLK),
        .nRESET        (nRESET),
        .i_enable      (i_enable),
        .i_vld         (i_vld),
        .i_is_sync     (i_is_sync),
        .i_timeout     (i_timeout),
        .i_confirm     (i_confirm),
        .o_dec_reset_n (o_dec_reset_n),
        .o_phase       (o_phase),
        .o_diff_en     (o_diff_en),
        .o_code_rate   (o_code_rate),
        .o_hyp_idx     (o_hyp_idx),
        .o_locked      (o_locked),
        .o_lost        (o_lost),
        .o_sweep_wrap  (o_sweep_wrap)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Behavioural model: "active" search session, remaining decoder-reset cycles,
    // symbols seen on this hypothesis, confirm progress (-1 = not confirming).
    int m_hyp = 0, m_rst_left = 0, m_syms = 0, m_conf = -1, m_miss = 0;
    bit m_active = 0, m_locked = 0, m_rstn = 0, m_lost = 0, m_wrap = 0;

    function automatic void m_restart();
        m_rst_left = RC;
        m_rstn     = 1'b0;
        m_conf     = -1;
        m_locked   = 1'b0;
    endfunction

    function automatic void m_advance();
        m_hyp = (m_hyp + 1) % NHYP;
        if (m_hyp == 0) m_wrap = 1'b1;
        m_restart();
    endfunction

    function automatic void model_step();
        int target;
        m_lost = 1'b0;
        m_wrap = 1'b0;
        target = (i_confirm == 8'd0) ? 1 : int'(i_confirm);
        if (!nRESET || !i_enable) begin
            m_active = 1'b0; m_hyp = 0; m_rstn = 1'b0; m_locked = 1'b0; m_conf = -1;
        end else if (!m_active) begin
            m_active = 1'b1;
            m_restart();
        end else if (m_rst_left > 0) begin
            m_rst_left--;
            if (m_rst_left == 0) begin
                m_rstn = 1'b1; m_syms = 0; m_conf = -1;
            end
        end else if (m_locked) begin
            if (i_vld) begin
                if (i_is_sync) m_miss = 0;
                else begin
                    m_miss++;
                    if (m_miss >= LL) begin
                        m_lost = 1'b1;
                        m_restart();
                    end
                end
            end
        end else if (m_conf >= 0) begin
            if (!i_is_sync) m_advance();
            else if (i_vld) begin
                m_conf++;
                if (m_conf >= target) begin
                    m_locked = 1'b1; m_miss = 0; m_conf = -1;
                end
            end
        end else begin
            if (i_vld) m_syms++;
            if (i_is_sync) m_conf = 0;
            else if (i_vld && i_timeout != '0 && m_syms >= int'(i_timeout)) m_advance();
        end
    endfunction

    task automatic compare_outputs();
        check_val("dec_reset_n", 32'(o_dec_reset_n), 32'(m_rstn));
        check_val("hyp_idx", 32'(o_hyp_idx), m_hyp);
        check_val("phase", 32'(o_phase), m_hyp % 4);
        check_val("diff_en", 32'(o_diff_en), (m_hyp / 4) % 2);
        check_val("code_rate", 32'(o_code_rate), m_hyp / 8);
        check_val("locked", 32'(o_locked), 32'(m_locked));
        check_val("lost", 32'(o_lost), 32'(m_lost));
        check_val("sweep_wrap", 32'(o_sweep_wrap), 32'(m_wrap));
    endtask

    task automatic cycle();
        @(posedge CLK);
        model_step();
        @(negedge CLK);
        compare_outputs();
    endtask

    function automatic bit m_waiting();
        return m_active && m_rst_left == 0 && !m_locked && m_conf < 0;
    endfunction

    initial begin
        int wraps, n, saved;
        bit ok;
        nRESET = 1'b0; i_enable = 1'b0; i_vld = 1'b0; i_is_sync = 1'b0;
        i_timeout = 24'd10; i_confirm = 8'd3;

        // Reset and idle
        repeat (4) cycle();
        nRESET = 1'b1;
        repeat (3) cycle();

        // Full sweep with no sync
        i_enable = 1'b1; i_vld = 1'b1;
        wraps = 0;
        repeat (1 + NHYP * (RC + 10) + 5) begin
            cycle();
            wraps += int'(o_sweep_wrap);
        end
        check_val("sweep_wrap_count", wraps, 1);

        // Acquisition on hypothesis 5
        i_enable = 1'b0; cycle(); i_enable = 1'b1;
        ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            cycle();
            ok = (m_hyp == 5) && m_waiting();
        end
        check_val("reach_hyp5", 32'(ok), 1);
        i_is_sync = 1'b1;
        n = 0;
        for (int i = 0; i < 20 && !o_locked; i++) begin
            cycle();
            n++;
        end
        check_val("acq_latency", n, 4);
        check_val("acq_locked", 32'(o_locked), 1);
        check_val("acq_hyp", 32'(o_hyp_idx), 5);

        // Loss just below the limit, then at the limit
        i_is_sync = 1'b0;
        repeat (LL - 1) cycle();
        i_is_sync = 1'b1; cycle();
        check_val("loss15_locked", 32'(o_locked), 1);
        i_is_sync = 1'b0;
        repeat (LL) cycle();
        check_val("loss16_lost", 32'(o_lost), 1);
        check_val("loss16_locked", 32'(o_locked), 0);
        check_val("loss16_rstn", 32'(o_dec_reset_n), 0);
        check_val("loss16_hyp", 32'(o_hyp_idx), 5);

        // False sync: one sync symbol then drop
        ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            cycle();
            ok = m_waiting();
        end
        check_val("false_wait", 32'(ok), 1);
        i_is_sync = 1'b1; cycle();
        i_is_sync = 1'b0; cycle();
        check_val("false_hyp", 32'(o_hyp_idx), 6);
        check_val("false_locked", 32'(o_locked), 0);

        // Sync coincident with the timeout symbol
        i_timeout = 24'd5;
        ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            cycle();
            ok = m_waiting() && m_syms == 4;
        end
        check_val("coinc_reach", 32'(ok), 1);
        saved = m_hyp;
        i_is_sync = 1'b1; cycle();
        check_val("coinc_hyp", 32'(o_hyp_idx), saved);
        check_val("coinc_rstn", 32'(o_dec_reset_n), 1);
        i_is_sync = 1'b0; cycle();

        // Enable drop in the middle of decoder reset
        i_timeout = 24'd3;
        ok = 0;
        for (int i = 0; i < 300 && !ok; i++) begin
            cycle();
            ok = m_hyp != 0 && m_rst_left > 0 && m_rst_left < RC;
        end
        check_val("endrop_reach", 32'(ok), 1);
        i_enable = 1'b0; cycle();
        check_val("endrop_hyp", 32'(o_hyp_idx), 0);
        check_val("endrop_rstn", 32'(o_dec_reset_n), 0);

        // Timeout of zero never advances
        i_timeout = '0; i_enable = 1'b1;
        repeat (300) cycle();
        check_val("tmo0_hyp", 32'(o_hyp_idx), 0);
        check_val("tmo0_rstn", 32'(o_dec_reset_n), 1);

        // Randomised traffic
        for (int i = 0; i < 4000; i++) begin
            i_vld = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) i_is_sync = ~i_is_sync;
            i_enable = ($urandom_range(0, 299) != 0);
            nRESET   = ($urandom_range(0, 999) != 0);
            if ($urandom_range(0, 99) == 0) i_timeout = TW'($urandom_range(0, 12));
            if ($urandom_range(0, 99) == 0) i_confirm = 8'($urandom_range(0, 4));
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fano_sync_ctrl.md
Name: fano_sync_ctrl

Overview:
- Acquisition scheduler for fano_decoder.
- Sweeps decoder configuration hypotheses (phase rotation, differential mode, code rate) until the decoder reports sync.
- Confirms lock, then supervises it and re-acquires on loss.
- Sits between the system config registers and fano_decoder; drives the decoder's reset and config inputs.

Parameters:
- TIMEOUT_WIDTH, 24: width of per-hypothesis symbol timeout counter and i_timeout.
- NUM_RATES, 4: number of code rates swept (1..4); rate index runs 0..NUM_RATES-1.
- RST_CYCLES, 4: cycles o_dec_reset_n is held low per hypothesis change (≥1).
- LOSS_LIMIT, 16: consecutive non-sync valid symbols in LOCKED that declare loss.

Ports:
- CLK  in  1  clock
- nRESET  in  1  reset, synchronous, active-low
- i_enable  in  1  search/track enable; low forces IDLE
- i_vld  in  1  symbol valid, same strobe as the decoder's i_vld
- i_is_sync  in  1  decoder o_is_sync
- i_timeout  in  TIMEOUT_WIDTH  valid symbols allowed per hypothesis; 0 = never time out
- i_confirm  in  8  valid symbols i_is_sync must hold before lock; 0 treated as 1
- o_dec_reset_n  out  1  decoder reset_n, ANDed externally with nRESET
- o_phase  out  2  phase rotation hypothesis (×90°)
- o_diff_en  out  1  decoder i_diff_en
- o_code_rate  out  2  decoder i_code_rate
- o_hyp_idx  out  5  current hypothesis index {rate, diff, phase}
- o_locked  out  1  lock confirmed
- o_lost  out  1  one-cycle pulse on loss of lock
- o_sweep_wrap  out  1  one-cycle pulse when sweep wraps without lock

Behaviour:
- Reset (nRESET=0 at posedge):
  - state IDLE; o_dec_reset_n=0.
  - o_phase, o_diff_en, o_code_rate, o_hyp_idx = 0.
  - o_locked, o_lost, o_sweep_wrap = 0.
  - All counters 0.
- All outputs are registered.
- Hypothesis order:
  - phase increments fastest; then diff_en; then code_rate.
  - After phase=3, diff=1, rate=NUM_RATES-1 the hypothesis wraps to 0 and o_sweep_wrap pulses in the same cycle the new hypothesis is loaded.
  - Total hypotheses = 8·NUM_RATES.
  - o_hyp_idx = {o_code_rate, o_diff_en, o_phase}.
- Config outputs change only in the cycle of entry to RST_DEC, when o_dec_reset_n goes 0 on the same edge.
- States:
  - IDLE:
    - o_dec_reset_n=0; hypothesis reset to 0.
    - i_enable=1 → RST_DEC.
  - RST_DEC:
    - o_dec_reset_n=0 for exactly RST_CYCLES cycles.
    - Then → WAIT_SYNC with o_dec_reset_n=1 and the symbol counter cleared.
  - WAIT_SYNC:
    - Each i_vld increments the symbol counter.
    - i_is_sync=1 → CONFIRM with the confirm counter cleared.
    - Otherwise, when i_vld arrives with counter == i_timeout-1 (i_timeout≠0): advance hypothesis → RST_DEC.
    - If i_is_sync and timeout occur in the same cycle, sync wins.
  - CONFIRM:
    - On each i_vld with i_is_sync=1, increment the confirm counter.
    - On reaching max(i_confirm,1) → LOCKED, o_locked=1 on the same edge.
    - If i_is_sync=0 in any cycle: advance hypothesis → RST_DEC (false sync).
  - LOCKED:
    - i_vld with i_is_sync=0 increments the loss counter.
    - i_vld with i_is_sync=1 clears it.
    - Loss counter reaching LOSS_LIMIT → o_locked=0, o_lost pulse, → RST_DEC keeping the SAME hypothesis (retry current first).
- i_enable=0 in any state → IDLE on the next edge; o_locked cleared; pending pulses not generated.
- i_timeout/i_confirm changes are sampled live; a lowered i_timeout below the current count takes effect at the next i_vld, where count ≥ i_timeout-1 triggers timeout.
- Counters saturate, never wrap.
- Latency from decision to decoder reset low: 1 cycle.

Test Plan:
- Reset/idle: nRESET low 4 cycles, i_enable=0 → o_dec_reset_n=0, o_hyp_idx=0, o_locked=0 throughout.
- Sweep timing: i_enable=1, i_timeout=10, i_is_sync=0, i_vld every cycle.
  - o_dec_reset_n low 4 cycles, then high 10 cycles per hypothesis.
  - o_hyp_idx steps 0,1,2,…,31,0.
  - o_sweep_wrap pulses once at the wrap to 0.
- Acquisition: i_is_sync forced high while o_hyp_idx=5 (phase=1, diff=1, rate=0), i_confirm=3.
  - o_locked rises after the 3rd valid symbol.
  - o_hyp_idx stays 5.
- False sync: i_is_sync high 1 symbol in CONFIRM with i_confirm=3 → next hypothesis (6) loaded, o_locked never asserts.
- Loss and relock:
  - In LOCKED, drop i_is_sync for 15 valid symbols then raise → stays locked.
  - Drop for 16 → o_lost pulse, o_locked=0, decoder reset, o_hyp_idx unchanged.
- Edge cases:
  - i_timeout=0 stays on hypothesis 0 indefinitely.
  - i_enable drop mid-RST_DEC → IDLE next cycle, o_hyp_idx=0.
  - i_is_sync coincident with the timeout symbol → CONFIRM, no hypothesis advance.
